// File: rtl/int_neuro_trainer_pkg.sv
// rtl/int_neuro_trainer_pkg.sv - Q3.12 constants, FSM state codes and saturating arithmetic helpers
package int_neuro_pkg;

    localparam logic [15:0] ONE     = 16'h1000;
    localparam logic [15:0] ZERO    = 16'h0000;
    localparam logic [15:0] SAT_MAX = 16'h7FFF;
    localparam logic [15:0] SAT_MIN = 16'h8000;

    typedef logic [3:0] state_t;
    localparam state_t S_IDLE = 4'd0;
    localparam state_t S_LOAD = 4'd1;
    localparam state_t S_MUL1 = 4'd2;
    localparam state_t S_MUL2 = 4'd3;
    localparam state_t S_ACT  = 4'd4;
    localparam state_t S_UPD1 = 4'd5;
    localparam state_t S_UPD2 = 4'd6;
    localparam state_t S_NEXT = 4'd7;
    localparam state_t S_DONE = 4'd8;

    // Overflow is detected by the two top bits of the 17-bit sum disagreeing.
    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
        logic signed [16:0] s;
        s = $signed({a[15], a}) + $signed({b[15], b});
        if (s[16] != s[15])
            return s[16] ? SAT_MIN : SAT_MAX;
        return s[15:0];
    endfunction

    function automatic logic [15:0] q_mul(input logic [15:0] a, input logic [15:0] b, input int frac);
        logic signed [31:0] prod;
        logic signed [31:0] sh;
        prod = $signed(a) * $signed(b);
        sh   = prod >>> frac;
        if (sh > 32'sd32767)
            return SAT_MAX;
        if (sh < -32'sd32768)
            return SAT_MIN;
        return sh[15:0];
    endfunction

endpackage

// File: rtl/int_neuro_trainer_if.sv
// rtl/int_neuro_trainer_if.sv - training request, training set and trained-weight bundle
interface int_neuro_trainer_if #(parameter int TAM = 16);
    logic                    start;
    logic [3:0][TAM-1:0]     in1;
    logic [3:0][TAM-1:0]     in2;
    logic [3:0][TAM-1:0]     d;
    logic [TAM-1:0]          w0_init;
    logic [TAM-1:0]          w1_init;
    logic [TAM-1:0]          w2_init;
    logic                    busy;
    logic                    done;
    logic                    converged;
    logic [7:0]              epoch_cnt;
    logic [TAM-1:0]          w0;
    logic [TAM-1:0]          w1;
    logic [TAM-1:0]          w2;

    modport master (
        output start, in1, in2, d, w0_init, w1_init, w2_init,
        input  busy, done, converged, epoch_cnt, w0, w1, w2
    );

    modport slave (
        input  start, in1, in2, d, w0_init, w1_init, w2_init,
        output busy, done, converged, epoch_cnt, w0, w1, w2
    );
endinterface

// File: rtl/int_mul_sat.sv
// rtl/int_mul_sat.sv - combinational signed Q3.12 multiply with 16-bit saturation
module int_mul_sat
    import int_neuro_pkg::*;
#(
    parameter int FRAC = 12
) (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] p
);
    assign p = q_mul(a, b, FRAC);
endmodule

// File: rtl/int_neuro_trainer.sv
// rtl/int_neuro_trainer.sv - sequential perceptron trainer sharing one Q3.12 multiplier
module int_neuro_trainer
    import int_neuro_pkg::*;
#(
    parameter int             TAM       = 16,
    parameter int             FRAC      = 12,
    parameter int             MAX_EPOCH = 64,
    parameter logic [TAM-1:0] ETA       = 16'h0200
) (
    input  logic              clk,
    input  logic              rst_n,
    int_neuro_trainer_if.slave bus
);
    localparam logic [7:0]     MAX_E   = 8'(MAX_EPOCH);
    localparam logic [TAM-1:0] NEG_ETA = ~ETA + 1'b1;

    state_t              state;
    logic [3:0][TAM-1:0] x1_r, x2_r, d_r;
    logic [TAM-1:0]      w0_r, w1_r, w2_r;
    logic [TAM-1:0]      acc, v, delta;
    logic [1:0]          idx;
    logic                err_flag;
    logic [7:0]          epoch_r;
    logic                conv_r;

    logic [TAM-1:0]      mul_a, mul_b, prod;
    logic [TAM-1:0]      y;
    logic signed [TAM:0] err_v;
    logic                e_zero, e_neg;

    // Single shared multiplier; the FSM state selects which product it forms.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            S_MUL1: begin mul_a = w1_r;  mul_b = x1_r[idx]; end
            S_MUL2: begin mul_a = w2_r;  mul_b = x2_r[idx]; end
            S_UPD1: begin mul_a = delta; mul_b = x1_r[idx]; end
            S_UPD2: begin mul_a = delta; mul_b = x2_r[idx]; end
            default: ;
        endcase
    end

    int_mul_sat #(.FRAC(FRAC)) u_mul (
        .a(mul_a),
        .b(mul_b),
        .p(prod)
    );

    always_comb begin
        y      = v[TAM-1] ? ZERO : ONE;
        err_v  = $signed({d_r[idx][TAM-1], d_r[idx]}) - $signed({y[TAM-1], y});
        e_zero = (err_v == '0);
        e_neg  = err_v[TAM];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            x1_r     <= '0;
            x2_r     <= '0;
            d_r      <= '0;
            w0_r     <= '0;
            w1_r     <= '0;
            w2_r     <= '0;
            acc      <= '0;
            v        <= '0;
            delta    <= '0;
            idx      <= '0;
            err_flag <= 1'b0;
            epoch_r  <= '0;
            conv_r   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (bus.start) state <= S_LOAD;
                S_LOAD: begin
                    x1_r     <= bus.in1;
                    x2_r     <= bus.in2;
                    d_r      <= bus.d;
                    w0_r     <= bus.w0_init;
                    w1_r     <= bus.w1_init;
                    w2_r     <= bus.w2_init;
                    idx      <= '0;
                    err_flag <= 1'b0;
                    epoch_r  <= '0;
                    conv_r   <= 1'b0;
                    state    <= S_MUL1;
                end
                S_MUL1: begin
                    acc   <= sat_add(w0_r, prod);
                    state <= S_MUL2;
                end
                S_MUL2: begin
                    v     <= sat_add(acc, prod);
                    state <= S_ACT;
                end
                S_ACT: begin
                    if (e_zero) begin
                        state <= S_NEXT;
                    end else begin
                        err_flag <= 1'b1;
                        delta    <= e_neg ? NEG_ETA : ETA;
                        w0_r     <= sat_add(w0_r, e_neg ? NEG_ETA : ETA);
                        state    <= S_UPD1;
                    end
                end
                S_UPD1: begin
                    w1_r  <= sat_add(w1_r, prod);
                    state <= S_UPD2;
                end
                S_UPD2: begin
                    w2_r  <= sat_add(w2_r, prod);
                    state <= S_NEXT;
                end
                S_NEXT: begin
                    if (idx != 2'd3) begin
                        idx   <= idx + 2'd1;
                        state <= S_MUL1;
                    end else begin
                        epoch_r <= epoch_r + 8'd1;
                        if (!err_flag) begin
                            conv_r <= 1'b1;
                            state  <= S_DONE;
                        end else if (epoch_r + 8'd1 == MAX_E) begin
                            state <= S_DONE;
                        end else begin
                            idx      <= '0;
                            err_flag <= 1'b0;
                            state    <= S_MUL1;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = (state != S_IDLE) && (state != S_DONE);
    assign bus.done      = (state == S_DONE);
    assign bus.converged = conv_r;
    assign bus.epoch_cnt = epoch_r;
    assign bus.w0        = w0_r;
    assign bus.w1        = w1_r;
    assign bus.w2        = w2_r;
endmodule
